// File: rtl/dp_vector_sequencer.sv
// dp_vector_sequencer
// Holds two vectors (A and B) as blocks of M signed N-bit elements. On a start
// command it streams blocks 0..len-1 to an external dot-product engine, one
// block per cycle. It then waits a bounded time for the engine's result and
// captures that result for a valid/ready consumer.
//
// Ports
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_wr_en/i_wr_addr         buffer write (accepted only while idle)
//   i_wr_a/i_wr_b             block data written to both vector buffers
//   i_start/i_len             start command, length in blocks (1..DEPTH)
//   o_a/o_b/o_first/o_last    block stream to the engine
//   i_sum/i_valid             engine result, single-cycle valid
//   o_result/o_result_valid   captured result, i_result_ready consumes it
//   o_busy                    command in progress
//   o_cmd_err                 one-cycle pulse for an illegal or dropped command
//   o_timeout/o_overrun       sticky status, cleared by the next accepted start
module dp_vector_sequencer #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int S     = 48,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [M*N-1:0]  i_wr_a,
  input  logic [M*N-1:0]  i_wr_b,
  input  logic            i_start,
  input  logic [AW:0]     i_len,
  output logic [M*N-1:0]  o_a,
  output logic [M*N-1:0]  o_b,
  output logic            o_first,
  output logic            o_last,
  input  logic [S-1:0]    i_sum,
  input  logic            i_valid,
  output logic [S-1:0]    o_result,
  output logic            o_result_valid,
  input  logic            i_result_ready,
  output logic            o_busy,
  output logic            o_cmd_err,
  output logic            o_timeout,
  output logic            o_overrun
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [M*N-1:0] r_mem_a [DEPTH];
  logic [M*N-1:0] r_mem_b [DEPTH];

  state_t         r_state;
  logic [AW-1:0]  r_idx;
  logic [AW-1:0]  r_last_idx;
  logic [1:0]     r_wait;
  logic           r_cmd_err;
  logic           r_timeout;
  logic           r_overrun;
  logic [S-1:0]   r_result;
  logic           r_result_valid;

  logic w_busy;
  logic w_stream;
  logic w_len_ok;
  logic w_addr_ok;

  assign w_busy    = (r_state != IDLE);
  assign w_stream  = (r_state == STREAM);
  assign w_len_ok  = (i_len != '0) && (i_len <= DEPTH_L);
  assign w_addr_ok = ({1'b0, i_wr_addr} < DEPTH_L);

  // The buffer read is combinational from the current index. A write to entry 0
  // in the same cycle as the start is therefore already visible on the first
  // streamed block.
  assign o_a     = w_stream ? r_mem_a[r_idx] : '0;
  assign o_b     = w_stream ? r_mem_b[r_idx] : '0;
  assign o_first = w_stream && (r_idx == '0);
  assign o_last  = w_stream && (r_idx == r_last_idx);

  assign o_busy         = w_busy;
  assign o_cmd_err      = r_cmd_err;
  assign o_timeout      = r_timeout;
  assign o_overrun      = r_overrun;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;

  // Buffer storage: not reset, contents survive reset
  always_ff @(posedge i_clk) begin
    if (i_wr_en && !w_busy && w_addr_ok) begin
      r_mem_a[i_wr_addr] <= i_wr_a;
      r_mem_b[i_wr_addr] <= i_wr_b;
    end
  end

  // Control FSM and result capture
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state        <= IDLE;
      r_idx          <= '0;
      r_last_idx     <= '0;
      r_wait         <= '0;
      r_cmd_err      <= 1'b0;
      r_timeout      <= 1'b0;
      r_overrun      <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_cmd_err <= (i_start && (w_busy || !w_len_ok)) ||
                   (i_wr_en && (w_busy || !w_addr_ok));

      // Consumption; a capture in the same cycle overrides this below
      if (r_result_valid && i_result_ready)
        r_result_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (i_start && w_len_ok) begin
            r_last_idx <= AW'(i_len - 1'b1);
            r_idx      <= '0;
            r_timeout  <= 1'b0;
            r_overrun  <= 1'b0;
            r_state    <= STREAM;
          end
        end
        STREAM: begin
          if (r_idx == r_last_idx) begin
            r_wait  <= '0;
            r_state <= WAIT_RES;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        WAIT_RES: begin
          // The engine answers two cycles after the last block. The wait window
          // covers four cycles after the last block before declaring a timeout.
          if (i_valid) begin
            r_result       <= i_sum;
            r_result_valid <= 1'b1;
            if (r_result_valid && !i_result_ready)
              r_overrun <= 1'b1;
            r_state <= IDLE;
          end else if (r_wait == 2'd3) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_vector_sequencer.sv
module tb_dp_vector_sequencer;
  localparam int N     = 8;
  localparam int M     = 4;
  localparam int S     = 48;
  localparam int DEPTH = 48;
  localparam int AW    = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            i_reset_n;
  logic            i_wr_en;
  logic [AW-1:0]   i_wr_addr;
  logic [M*N-1:0]  i_wr_a, i_wr_b;
  logic            i_start;
  logic [AW:0]     i_len;
  logic [M*N-1:0]  o_a, o_b;
  logic            o_first, o_last;
  logic [S-1:0]    i_sum;
  logic            i_valid;
  logic [S-1:0]    o_result;
  logic            o_result_valid;
  logic            i_result_ready;
  logic            o_busy, o_cmd_err, o_timeout, o_overrun;

  // Engine stub and spurious-valid injector share the engine input pins
  logic            eng_valid = 1'b0, spur_valid = 1'b0;
  logic [S-1:0]    eng_sum = '0, spur_sum = '0;
  bit              eng_suppress = 1'b0;
  assign i_valid = eng_valid | spur_valid;
  assign i_sum   = eng_valid ? eng_sum : spur_sum;

  dp_vector_sequencer #(.N(N), .M(M), .S(S), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_a(i_wr_a), .i_wr_b(i_wr_b), .i_start(i_start), .i_len(i_len),
    .o_a(o_a), .o_b(o_b), .o_first(o_first), .o_last(o_last),
    .i_sum(i_sum), .i_valid(i_valid), .o_result(o_result),
    .o_result_valid(o_result_valid), .i_result_ready(i_result_ready),
    .o_busy(o_busy), .o_cmd_err(o_cmd_err), .o_timeout(o_timeout),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [M*N-1:0] a;
    logic [M*N-1:0] b;
    bit             first;
    bit             last;
  } blk_t;

  blk_t           exp_blk[$];
  logic [S-1:0]   exp_res[$];
  logic [M*N-1:0] sh_a[DEPTH];
  logic [M*N-1:0] sh_b[DEPTH];
  int             checks = 0;
  int             passed = 0;
  int             last_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic longint dot(input logic [M*N-1:0] a, input logic [M*N-1:0] b);
    longint s = 0;
    for (int i = 0; i < M; i++) begin
      logic signed [N-1:0] x, y;
      x = a[i*N +: N];
      y = b[i*N +: N];
      s += longint'(x) * longint'(y);
    end
    return s;
  endfunction

  function automatic logic [S-1:0] ref_sum(input int len);
    longint s = 0;
    for (int k = 0; k < len; k++) s += dot(sh_a[k], sh_b[k]);
    return S'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an accepted command streams the shadow buffer in order
  task automatic push_cmd(input int len, input bit want_res);
    for (int k = 0; k < len; k++) begin
      blk_t e;
      e.a = sh_a[k]; e.b = sh_b[k]; e.first = (k == 0); e.last = (k == len - 1);
      exp_blk.push_back(e);
    end
    if (want_res) exp_res.push_back(ref_sum(len));
  endtask

  task automatic start_cmd(input int len, input bit accept, input bit want_res);
    i_start = 1'b1;
    i_len   = (AW+1)'(len);
    if (accept) push_cmd(len, want_res);
    tick();
    i_start = 1'b0;
  endtask

  task automatic wr(input int addr, input logic [M*N-1:0] a, input logic [M*N-1:0] b,
                    input bit accept);
    i_wr_en = 1'b1; i_wr_addr = AW'(addr); i_wr_a = a; i_wr_b = b;
    if (accept) begin sh_a[addr] = a; sh_b[addr] = b; end
    tick();
    i_wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 200) begin tick(); n++; end
    check("idle_reached", o_busy, 0);
  endtask

  // Engine stub: accumulates the streamed blocks, answers two cycles after o_last
  initial begin
    longint acc = 0;
    bit on = 0;
    forever begin
      @(negedge clk);
      if (!i_reset_n) begin
        on = 0; acc = 0;
      end else if (o_first || on) begin
        if (o_first) acc = 0;
        acc += dot(o_a, o_b);
        on = 1;
        if (o_last) begin
          on = 0;
          @(posedge clk);
          @(posedge clk);
          #1;
          if (!eng_suppress && i_reset_n) begin
            eng_valid = 1'b1; eng_sum = S'(acc);
          end
          @(posedge clk);
          #1;
          eng_valid = 1'b0;
        end
      end
    end
  end

  // Stream monitor
  initial begin
    bit in_prog = 0;
    forever begin
      @(negedge clk);
      if (o_last) last_cnt++;
      if (!i_reset_n) begin
        exp_blk.delete();
        in_prog = 0;
      end else if (o_first || in_prog) begin
        if (exp_blk.size() == 0) begin
          check("unexpected_block", 1, 0);
          in_prog = 0;
        end else begin
          blk_t e;
          e = exp_blk.pop_front();
          check("blk_a", o_a, e.a);
          check("blk_b", o_b, e.b);
          check("blk_first", o_first, e.first);
          check("blk_last", o_last, e.last);
          in_prog = !e.last;
        end
      end else begin
        check("idle_stream_zero", (|o_a) | (|o_b) | o_first | o_last, 0);
      end
    end
  end

  // Result monitor
  initial begin
    forever begin
      @(negedge clk);
      if (i_reset_n && o_result_valid && i_result_ready) begin
        if (exp_res.size() == 0) check("unexpected_result", 1, 0);
        else check("result", o_result, exp_res.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [S-1:0] s1, s2;
    int cnt0;
    i_reset_n = 1'b0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_a = '0; i_wr_b = '0;
    i_start = 1'b0; i_len = '0; i_result_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin sh_a[k] = '0; sh_b[k] = '0; end
    repeat (3) tick();
    check("rst_busy", o_busy, 0);
    check("rst_result_valid", o_result_valid, 0);
    check("rst_result", o_result, 0);
    check("rst_flags", {o_cmd_err, o_timeout, o_overrun, o_first, o_last}, 0);
    check("rst_a", o_a, 0);
    i_reset_n = 1'b1; i_result_ready = 1'b1;
    // Buffer was never written: load the whole shadow-visible range
    for (int k = 0; k < DEPTH; k++) wr(k, $urandom, $urandom, 1);

    // Basic length-4 vector of ones
    for (int k = 0; k < 4; k++) wr(k, {4{8'h01}}, {4{8'h01}}, 1);
    start_cmd(4, 1, 1);
    check("l4_first", o_first, 1);
    check("l4_busy", o_busy, 1);
    tick(); tick();
    check("l4_not_last", o_last, 0);
    tick();
    check("l4_last", o_last, 1);
    wait_idle();
    check("l4_value", o_result, 16);
    check("l4_valid", o_result_valid, 1);
    tick();

    // Single-block extremes
    wr(0, 32'h807FFF02, 32'h807FFF02, 1);
    start_cmd(1, 1, 1);
    check("l1_first_last", {o_first, o_last}, 2'b11);
    wait_idle();
    check("l1_value", o_result, 32518);
    tick();

    // Write to entry 0 in the same cycle as start
    i_wr_en = 1'b1; i_wr_addr = '0; i_wr_a = 32'h01020304; i_wr_b = 32'hFFFEFDFC;
    sh_a[0] = i_wr_a; sh_b[0] = i_wr_b;
    start_cmd(2, 1, 1);
    i_wr_en = 1'b0;
    check("wr_start_a0", o_a, 32'h01020304);
    wait_idle();
    tick();

    // Command errors
    start_cmd(0, 0, 0);
    check("err_len0", o_cmd_err, 1);
    tick();
    check("err_clear", o_cmd_err, 0);
    start_cmd(DEPTH + 1, 0, 0);
    check("err_len_big", o_cmd_err, 1);
    wr(50, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    check("err_addr_big", o_cmd_err, 1);
    start_cmd(6, 1, 1);
    start_cmd(2, 0, 0);
    check("err_start_busy", o_cmd_err, 1);
    wr(5, 32'h5A5A5A5A, 32'hA5A5A5A5, 0);
    check("err_wr_busy", o_cmd_err, 1);
    wait_idle();
    tick();
    start_cmd(6, 1, 1); // entry 5 must still hold its old contents
    wait_idle();
    tick();

    // Timeout
    eng_suppress = 1'b1;
    start_cmd(3, 1, 0);
    repeat (6) tick();
    check("to_not_yet", {o_timeout, o_busy}, 2'b01);
    tick();
    check("to_set", {o_timeout, o_busy, o_result_valid}, 3'b100);
    eng_suppress = 1'b0;
    // A valid outside the wait window must be ignored
    spur_valid = 1'b1; spur_sum = 48'h123;
    tick();
    spur_valid = 1'b0;
    tick();
    check("spur_ignored", o_result_valid, 0);
    start_cmd(1, 1, 1);
    check("to_cleared", o_timeout, 0);
    wait_idle();
    tick();

    // Overrun: two commands with no consumer
    i_result_ready = 1'b0;
    wr(0, 32'h11223344, 32'h05060708, 1);
    wr(1, 32'hF0E0D0C0, 32'h7F7F8080, 1);
    s1 = ref_sum(2);
    start_cmd(2, 1, 0);
    wait_idle();
    check("ov_first_res", o_result, s1);
    check("ov_none_yet", {o_result_valid, o_overrun}, 2'b10);
    wr(1, 32'h01010101, 32'h80808080, 1);
    s2 = ref_sum(2);
    start_cmd(2, 1, 0);
    wait_idle();
    check("ov_set", {o_result_valid, o_overrun}, 2'b11);
    check("ov_second_res", o_result, s2);
    // Capture coincident with consumption: no overrun
    exp_res.push_back(s2);
    start_cmd(1, 1, 0);
    check("ov_cleared", o_overrun, 0);
    tick(); tick();
    i_result_ready = 1'b1;
    tick();
    i_result_ready = 1'b0;
    check("cc_valid", {o_result_valid, o_overrun}, 2'b10);
    check("cc_res", o_result, ref_sum(1));
    exp_res.push_back(ref_sum(1));
    i_result_ready = 1'b1;
    tick(); tick();
    check("cc_drained", o_result_valid, 0);

    // Reset in the middle of a length-8 stream
    cnt0 = last_cnt;
    start_cmd(8, 1, 0);
    tick(); tick();
    i_reset_n = 1'b0;
    tick();
    check("mr_outputs", {o_busy, o_first, o_last, o_result_valid, o_timeout, o_overrun,
                         o_cmd_err}, 0);
    check("mr_data", {o_a, o_result}, 0);
    i_reset_n = 1'b1;
    repeat (6) tick();
    check("mr_no_last", last_cnt, cnt0);
    check("mr_no_result", o_result_valid, 0);

    // Randomized commands
    for (int it = 0; it < 25; it++) begin
      int len;
      repeat ($urandom_range(0, 4)) wr($urandom_range(0, DEPTH - 1), $urandom, $urandom, 1);
      len = (it == 24) ? DEPTH : $urandom_range(1, 12);
      start_cmd(len, 1, 1);
      wait_idle();
      tick();
    end

    repeat (4) tick();
    check("blk_queue_empty", exp_blk.size(), 0);
    check("res_queue_empty", exp_res.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
